// File: rtl/pipe_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub_if
// Brief    : Operand/result handshake bundle for the pipelined adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output in_sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  in_sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout,
        output out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub
// Brief    : WIDTH-bit adder/subtractor, carry chain split into CHUNK-bit
//            pipeline stages with a valid/ready handshake and global stall.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("pipe_addsub: WIDTH must be an integer multiple of CHUNK");
        end
    endgenerate

    logic             advance;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;

    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             ovf_q;

    // Subtraction is folded into the operands once at the input: A + ~B + ~cin.
    always_comb begin
        advance = !valid_q[STAGES-1] || bus.out_ready;
        b_in    = bus.in_sub ? ~bus.in_b : bus.in_b;
        cin_in  = bus.in_sub ? ~bus.in_cin : bus.in_cin;
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] src_a;
            logic [WIDTH-1:0] src_b;
            logic [WIDTH-1:0] src_sum;
            logic             src_c;
            logic             src_v;
            logic [CHUNK:0]   part;
            logic             valid_d;
            logic             carry_d;
            logic [WIDTH-1:0] a_d;
            logic [WIDTH-1:0] b_d;
            logic [WIDTH-1:0] sum_d;

            if (k == 0) begin : g_head
                assign src_a   = bus.in_a;
                assign src_b   = b_in;
                assign src_sum = '0;
                assign src_c   = cin_in;
                assign src_v   = bus.in_valid;
            end else begin : g_body
                assign src_a   = a_q[k-1];
                assign src_b   = b_q[k-1];
                assign src_sum = sum_q[k-1];
                assign src_c   = carry_q[k-1];
                assign src_v   = valid_q[k-1];
            end

            // Operands travel whole so upper chunks stay skewed; finished chunks accumulate in sum.
            always_comb begin
                part    = {1'b0, src_a[k*CHUNK +: CHUNK]}
                        + {1'b0, src_b[k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, src_c};
                sum_d   = src_sum;
                sum_d[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
                carry_d = part[CHUNK];
                a_d     = src_a;
                b_d     = src_b;
                valid_d = src_v;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q[k] <= 1'b0;
                    carry_q[k] <= 1'b0;
                    a_q[k]     <= '0;
                    b_q[k]     <= '0;
                    sum_q[k]   <= '0;
                end else if (advance) begin
                    valid_q[k] <= valid_d;
                    carry_q[k] <= carry_d;
                    a_q[k]     <= a_d;
                    b_q[k]     <= b_d;
                    sum_q[k]   <= sum_d;
                end
            end

            if (k == STAGES - 1) begin : g_tail
                logic ovf_d;

                // Carry into the MSB is recovered from the MSB's own sum bit.
                always_comb begin
                    ovf_d = (src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ part[CHUNK-1]) ^ part[CHUNK];
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        ovf_q <= 1'b0;
                    end else if (advance) begin
                        ovf_q <= ovf_d;
                    end
                end
            end
        end
    endgenerate

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_sum   = sum_q[STAGES-1];
    assign bus.out_cout  = carry_q[STAGES-1];
    assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_addsub
// Brief    : Scoreboard bench for pipe_addsub at 16/4 and 4/4 configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_addsub_if #(.WIDTH(16)) if16 ();
    pipe_addsub_if #(.WIDTH(4))  if4 ();

    pipe_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    pipe_addsub #(.WIDTH(4),  .CHUNK(4)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] exp16_q [$];
    logic [5:0]  exp4_q  [$];
    logic        held16_v = 1'b0;
    logic [17:0] held16;
    bit          prod_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference: integer arithmetic; returns {sum[15:0], cout, ovf}.
    function automatic logic [17:0] model(input int w, input longint a, input longint b,
                                          input bit cin, input bit sub);
        longint m, ci, u, sa, sb, s, sum;
        bit     cout, ovf;
        logic [15:0] s16;
        m  = longint'(1) << w;
        ci = longint'(cin);
        if (!sub) begin
            u    = a + b + ci;
            cout = (u >= m);
            sum  = u % m;
        end else begin
            u    = a - b - ci;
            cout = (u >= 0);
            sum  = (u + m) % m;
        end
        sa  = (a >= m / 2) ? a - m : a;
        sb  = (b >= m / 2) ? b - m : b;
        s   = sub ? (sa - sb - ci) : (sa + sb + ci);
        ovf = (s < -(m / 2)) || (s >= m / 2);
        s16 = 16'(sum);
        return {s16, cout, ovf};
    endfunction

    // Monitor and scoreboard
    always @(negedge clk) begin
        logic [17:0] e16;
        logic [5:0]  e4;
        if (!rst_n) begin
            exp16_q.delete();
            exp4_q.delete();
            held16_v = 1'b0;
        end else begin
            if (held16_v)
                check("hold16", {if16.out_valid, if16.out_sum, if16.out_cout, if16.out_ovf},
                      {1'b1, held16});
            held16_v = if16.out_valid && !if16.out_ready;
            held16   = {if16.out_sum, if16.out_cout, if16.out_ovf};
            if (if16.out_valid && !if16.out_ready)
                check("in_ready_stall16", 32'(if16.in_ready), 32'd0);

            if (if16.out_valid && if16.out_ready) begin
                if (exp16_q.size() == 0) begin
                    check("unexpected_out16", {if16.out_sum, if16.out_cout, if16.out_ovf}, 32'hDEAD0000);
                end else begin
                    e16 = exp16_q.pop_front();
                    check("result16", {if16.out_sum, if16.out_cout, if16.out_ovf}, e16);
                end
            end
            if (if4.out_valid && if4.out_ready) begin
                if (exp4_q.size() == 0) begin
                    check("unexpected_out4", {if4.out_sum, if4.out_cout, if4.out_ovf}, 32'hDEAD0000);
                end else begin
                    e4 = exp4_q.pop_front();
                    check("result4", {if4.out_sum, if4.out_cout, if4.out_ovf}, e4);
                end
            end

            if (if16.in_valid && if16.in_ready)
                exp16_q.push_back(model(16, longint'(if16.in_a), longint'(if16.in_b),
                                        if16.in_cin, if16.in_sub));
            if (if4.in_valid && if4.in_ready) begin
                e16 = model(4, longint'(if4.in_a), longint'(if4.in_b), if4.in_cin, if4.in_sub);
                exp4_q.push_back(e16[5:0]);
            end
        end
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        if16.in_a = a; if16.in_b = b; if16.in_cin = cin; if16.in_sub = sub;
        if16.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if16.in_ready) begin
                @(posedge clk); #1;
                if16.in_valid = 1'b0;
                return;
            end
        end
        if16.in_valid = 1'b0;
        fail_now("send16");
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
        if4.in_a = a; if4.in_b = b; if4.in_cin = cin; if4.in_sub = sub;
        if4.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if4.in_ready) begin
                @(posedge clk); #1;
                if4.in_valid = 1'b0;
                return;
            end
        end
        if4.in_valid = 1'b0;
        fail_now("send4");
    endtask

    // Count accept edge plus edges until out_valid first seen.
    task automatic lat16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int cnt;
        send16(a, b, cin, sub);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if16.out_valid) break;
            @(posedge clk);
            cnt++;
        end
        check("latency16", 32'(cnt), 32'd4);
        @(posedge clk); #1;
    endtask

    task automatic lat4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
        int cnt;
        send4(a, b, cin, sub);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if4.out_valid) break;
            @(posedge clk);
            cnt++;
        end
        check("latency4", 32'(cnt), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp16_q.size() == 0 && exp4_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain16", 32'(exp16_q.size()), 32'd0);
        check("drain4", 32'(exp4_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_cin = 1'b0; if16.in_sub = 1'b0;
        if16.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.in_a = '0; if4.in_b = '0; if4.in_cin = 1'b0; if4.in_sub = 1'b0;
        if4.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid16", 32'(if16.out_valid), 32'd0);
        check("rst_out_sum16", 32'(if16.out_sum), 32'h0000);
        check("rst_out_cout16", 32'(if16.out_cout), 32'd0);
        check("rst_out_ovf16", 32'(if16.out_ovf), 32'd0);
        check("rst_in_ready16", 32'(if16.in_ready), 32'd1);
        check("rst_out_valid4", 32'(if4.out_valid), 32'd0);
        check("rst_out_sum4", 32'(if4.out_sum), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Carry ripple, wrap and signed-overflow corners
        lat16(16'h00FF, 16'h0001, 1'b0, 1'b0);
        lat16(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        lat16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        lat16(16'h0005, 16'h0007, 1'b0, 1'b1);
        lat16(16'h8000, 16'h0001, 1'b0, 1'b1);
        lat16(16'h0010, 16'h0001, 1'b1, 1'b1);

        // Back-to-back burst with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send16(16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()));
            end
            begin
                repeat (5) @(posedge clk);
                #1 if16.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 if16.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three results in flight, plus an input offered during reset
        for (int i = 0; i < 3; i++)
            send16(16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()));
        rst_n = 1'b0;
        if16.in_a = 16'h1234; if16.in_b = 16'h4321; if16.in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        if16.in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(if16.out_valid), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_queue", 32'(exp16_q.size()), 32'd0);

        // Random traffic with input gaps and random backpressure
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send16(16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()));
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    @(posedge clk); #1;
                    if16.out_ready = ($urandom_range(0, 3) != 0);
                end
                if16.out_ready = 1'b1;
            end
        join
        drain();

        // Single-stage configuration: latency then exhaustive sweep
        lat4(4'hF, 4'h1, 1'b0, 1'b0);
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        send4(4'(a), 4'(b), 1'(c), 1'(s));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
